// File: rtl/ic7458_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ic7458_pkg : shared types and constants for the 7458 exerciser.
// Rev 1.0
// ---------------------------------------------------------------------------
package ic7458_pkg;

    localparam int NUM_VECTORS = 1024;
    localparam int VEC_W       = 10;

    // Bit positions of each device pin inside the stim / vector word
    localparam int P1A = 0;
    localparam int P1B = 1;
    localparam int P1C = 2;
    localparam int P1D = 3;
    localparam int P1E = 4;
    localparam int P1F = 5;
    localparam int P2A = 6;
    localparam int P2B = 7;
    localparam int P2C = 8;
    localparam int P2D = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : ic7458_pkg
`default_nettype wire

// File: rtl/ic7458_golden.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ic7458_golden : combinational reference of the 7458 dual AND-OR gate.
// Rev 1.0
// ---------------------------------------------------------------------------
module ic7458_golden
    import ic7458_pkg::*;
(
    input  logic [VEC_W-1:0] i_vec,
    output logic             o_exp1,
    output logic             o_exp2
);

    assign o_exp1 = (i_vec[P1A] & i_vec[P1B] & i_vec[P1C])
                  | (i_vec[P1D] & i_vec[P1E] & i_vec[P1F]);
    assign o_exp2 = (i_vec[P2A] & i_vec[P2B])
                  | (i_vec[P2C] & i_vec[P2D]);

endmodule : ic7458_golden
`default_nettype wire

// File: rtl/ic7458_exerciser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ic7458_exerciser : sweeps all 1024 input vectors of a 7458 and checks
//                    both outputs against the golden AND-OR function.
// Rev 1.0
// ---------------------------------------------------------------------------
module ic7458_exerciser
    import ic7458_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [10:0]      fail_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic [VEC_W-1:0] stim,
    input  logic             dut_p1y,
    input  logic             dut_p2y
);

    localparam logic [3:0] C_SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] C_LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_t           r_state;
    logic [VEC_W-1:0] r_vec;
    logic [3:0]       r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [10:0]      r_fail_count;
    logic             r_ffv;
    logic [VEC_W-1:0] r_ffvec;
    logic [VEC_W-1:0] r_stim;

    logic             w_exp1;
    logic             w_exp2;
    logic             w_mismatch;
    logic [10:0]      w_fail_next;
    logic             w_finish;

    ic7458_golden u_golden (
        .i_vec  (r_vec),
        .o_exp1 (w_exp1),
        .o_exp2 (w_exp2)
    );

    assign w_mismatch  = ({dut_p2y, dut_p1y} != {w_exp2, w_exp1});
    assign w_fail_next = r_fail_count + {10'd0, w_mismatch};
    // Termination is decided before the increment, so r_vec never wraps
    assign w_finish    = (r_vec == C_LAST_VEC) || (STOP_ON_FAIL && w_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_count <= '0;
            r_ffv        <= 1'b0;
            r_ffvec      <= '0;
            r_stim       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_vec        <= '0;
                        r_stim       <= '0;
                        r_settle     <= C_SETTLE_RELOAD;
                        r_fail_count <= '0;
                        r_ffv        <= 1'b0;
                        r_ffvec      <= '0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == 4'd0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_fail_count <= w_fail_next;
                    if (w_mismatch && !r_ffv) begin
                        r_ffv   <= 1'b1;
                        r_ffvec <= r_vec;
                    end
                    if (w_finish) begin
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_next == 11'd0);
                        r_state <= ST_DONE;
                    end else begin
                        r_vec    <= r_vec + 10'd1;
                        r_stim   <= r_vec + 10'd1;
                        r_settle <= C_SETTLE_RELOAD;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign fail_count       = r_fail_count;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;
    assign stim             = r_stim;

endmodule : ic7458_exerciser
`default_nettype wire

// File: tb/tb_ic7458_exerciser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ic7458_exerciser : directed bench for ic7458_exerciser with a
//                       behavioural 7458 model and injectable stuck faults.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ic7458_exerciser;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    int         errors;
    int         checks;

    // Device fault mode per instance: 0 good, 1 1Y stuck-0, 2 2Y stuck-1
    int mode_a;
    int mode_b;
    int mode_c;

    logic        busy_a, done_a, pass_a, ffv_a, p1y_a, p2y_a;
    logic [10:0] fc_a;
    logic [9:0]  ffvec_a, stim_a;
    logic        busy_b, done_b, pass_b, ffv_b, p1y_b, p2y_b;
    logic [10:0] fc_b;
    logic [9:0]  ffvec_b, stim_b;
    logic        busy_c, done_c, pass_c, ffv_c, p1y_c, p2y_c;
    logic [10:0] fc_c;
    logic [9:0]  ffvec_c, stim_c;

    function automatic logic g1(input logic [9:0] v);
        return (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]);
    endfunction

    function automatic logic g2(input logic [9:0] v);
        return (v[6] & v[7]) | (v[8] & v[9]);
    endfunction

    always_comb begin
        p1y_a = (mode_a == 1) ? 1'b0 : g1(stim_a);
        p2y_a = (mode_a == 2) ? 1'b1 : g2(stim_a);
        p1y_b = (mode_b == 1) ? 1'b0 : g1(stim_b);
        p2y_b = (mode_b == 2) ? 1'b1 : g2(stim_b);
        p1y_c = (mode_c == 1) ? 1'b0 : g1(stim_c);
        p2y_c = (mode_c == 2) ? 1'b1 : g2(stim_c);
    end

    ic7458_exerciser #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_a),
        .done(done_a), .pass(pass_a), .fail_count(fc_a),
        .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a), .stim(stim_a),
        .dut_p1y(p1y_a), .dut_p2y(p2y_a)
    );

    ic7458_exerciser #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_b),
        .done(done_b), .pass(pass_b), .fail_count(fc_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b), .stim(stim_b),
        .dut_p1y(p1y_b), .dut_p2y(p2y_b)
    );

    ic7458_exerciser #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_c),
        .done(done_c), .pass(pass_c), .fail_count(fc_c),
        .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c), .stim(stim_c),
        .dut_p1y(p1y_c), .dut_p2y(p2y_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Pulse start for one edge; cyc = cycle number (1 = first after accept) of done
    task automatic start_and_wait(input int inst, output int cyc);
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(posedge clk);
        #1 start_v[inst] = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 5000; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_of(inst)) begin
                cyc = k + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, pass_a, ffv_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {busy_a, done_a, pass_a, ffv_a});
        end
        checks++;
        if ({fc_a, ffvec_a, stim_a} !== 31'd0) begin
            errors++;
            $display("FAIL reset_values: fc=%0d ffvec=%0d stim=%0d want 0", fc_a, ffvec_a, stim_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_sweep();
        int cyc;
        mode_a = 0;
        start_and_wait(0, cyc);
        checks++;
        if (cyc !== 3073) begin
            errors++;
            $display("FAIL good_done_cycle: got %0d want 3073", cyc);
        end
        checks++;
        if ({pass_a, fc_a, ffv_a} !== {1'b1, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL good_result: pass=%b fc=%0d ffv=%b want 1/0/0", pass_a, fc_a, ffv_a);
        end
        checks++;
        if (stim_a !== 10'd1023) begin
            errors++;
            $display("FAIL good_stim_hold: got %0d want 1023", stim_a);
        end
        @(negedge clk);
        checks++;
        if ({done_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL good_done_pulse: done=%b busy=%b want 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_p1_stuck();
        int cyc;
        mode_a = 1;
        start_and_wait(0, cyc);
        checks++;
        if ({fc_a, ffv_a, ffvec_a, pass_a} !== {11'd240, 1'b1, 10'd7, 1'b0}) begin
            errors++;
            $display("FAIL p1_stuck: fc=%0d ffv=%b ffvec=%0d pass=%b want 240/1/7/0",
                     fc_a, ffv_a, ffvec_a, pass_a);
        end
        mode_a = 0;
    endtask

    task automatic test_p2_stuck();
        int cyc;
        mode_a = 2;
        start_and_wait(0, cyc);
        checks++;
        if (cyc !== 3073) begin
            errors++;
            $display("FAIL p2_done_cycle: got %0d want 3073", cyc);
        end
        checks++;
        if ({fc_a, ffv_a, ffvec_a, pass_a} !== {11'd576, 1'b1, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL p2_stuck: fc=%0d ffv=%b ffvec=%0d pass=%b want 576/1/0/0",
                     fc_a, ffv_a, ffvec_a, pass_a);
        end
        mode_a = 0;
    endtask

    task automatic test_stop_on_fail();
        int cyc;
        mode_b = 1;
        start_and_wait(1, cyc);
        checks++;
        if (cyc !== 25) begin
            errors++;
            $display("FAIL stop_done_cycle: got %0d want 25", cyc);
        end
        checks++;
        if ({fc_b, ffvec_b, stim_b, pass_b} !== {11'd1, 10'd7, 10'd7, 1'b0}) begin
            errors++;
            $display("FAIL stop_result: fc=%0d ffvec=%0d stim=%0d pass=%b want 1/7/7/0",
                     fc_b, ffvec_b, stim_b, pass_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({stim_b, busy_b} !== {10'd7, 1'b0}) begin
            errors++;
            $display("FAIL stop_hold: stim=%0d busy=%b want 7 0", stim_b, busy_b);
        end
    endtask

    task automatic test_settle1();
        int cyc;
        logic [9:0] want;
        mode_c = 0;
        cyc = -1;
        @(negedge clk);
        start_v[2] = 1'b1;
        @(posedge clk);
        #1 start_v[2] = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1 || k == 2 || k == 4 || k == 7) begin
                want = 10'(k / 2);
                checks++;
                if (stim_c !== want) begin
                    errors++;
                    $display("FAIL settle1_stim_k%0d: got %0d want %0d", k, stim_c, want);
                end
            end
            if (done_c) begin
                cyc = k + 1;
                break;
            end
        end
        checks++;
        if ({cyc == 2049, pass_c, fc_c} !== {1'b1, 1'b1, 11'd0}) begin
            errors++;
            $display("FAIL settle1_sweep: cycle=%0d pass=%b fc=%0d want 2049/1/0", cyc, pass_c, fc_c);
        end
    endtask

    task automatic test_restart_and_reset();
        int cyc;
        int done_seen;
        mode_a = 0;
        // Re-pulse start mid-sweep; it must not disturb timing
        cyc = -1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({busy_a, fc_a, pass_a} !== {1'b1, 11'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL restart_clear: busy=%b fc=%0d pass=%b want 1/0/0", busy_a, fc_a, pass_a);
                end
            end
            if (k == 99) start_v[0] = 1'b1;
            if (k == 100) start_v[0] = 1'b0;
            if (done_a) begin
                cyc = k + 1;
                break;
            end
        end
        checks++;
        if ({cyc == 3073, pass_a} !== 2'b11) begin
            errors++;
            $display("FAIL restart_ignored: done cycle=%0d pass=%b want 3073/1", cyc, pass_a);
        end
        // Reset at cycle 500 of a fresh sweep
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (499) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, pass_a, ffv_a, fc_a, ffvec_a, stim_a} !== 35'd0) begin
            errors++;
            $display("FAIL midreset: busy=%b done=%b pass=%b fc=%0d stim=%0d want all 0",
                     busy_a, done_a, pass_a, fc_a, stim_a);
        end
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done_a || busy_a) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: activity count=%0d want 0", done_seen);
        end
        start_and_wait(0, cyc);
        checks++;
        if ({cyc == 3073, pass_a, fc_a} !== {1'b1, 1'b1, 11'd0}) begin
            errors++;
            $display("FAIL post_reset_sweep: cycle=%0d pass=%b fc=%0d want 3073/1/0", cyc, pass_a, fc_a);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        start_v = 3'b000;
        mode_a  = 0;
        mode_b  = 0;
        mode_c  = 0;
        rst_n   = 1'b0;
        test_reset();
        test_good_sweep();
        test_p1_stuck();
        test_p2_stuck();
        test_stop_on_fail();
        test_settle1();
        test_restart_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ic7458_exerciser
`default_nettype wire
